double_word_countdown_timer: RTL and testbench

//  Double-word-wide countdown timer peripheral. Sits directly behind double_word_adapter.
//  - Consumes the adapter's double_data_to_write / double_load.
//  - Feeds the adapter's double_data_to_read / double_read.
//  - Word-wide control/status register sits directly on the data bus.
//  - Raises an interrupt-capable expiry flag when the count passes through zero.

---
 rtl/double_word_countdown_timer.sv | 98 +++++++++
 tb/tb_double_word_countdown_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/double_word_countdown_timer.sv
// Double-word countdown timer sitting behind double_word_adapter: prescaled down-counter
// with reload, one-shot/auto-reload modes, sticky expired flag and registered irq.
module double_word_countdown_timer #(
    parameter int WW   = 16,
    parameter int MSB  = WW - 1,
    parameter int DW   = WW * 2,
    parameter int DMSB = DW - 1
) (
    input  logic          sysclk,
    input  logic          sysreset,
    input  logic [DMSB:0] double_data_to_write,
    input  logic          double_load,
    output logic [DMSB:0] double_data_to_read,
    input  logic          double_read,
    input  logic [MSB:0]  data_in,
    input  logic          load_ctrl,
    input  logic          read_ctrl,
    output logic [MSB:0]  ctrl_out,
    output logic          expire_pulse,
    output logic          irq
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          state;
    logic          auto_reload;
    logic          irq_en;
    logic          expired;
    logic [7:0]    prescale;
    logic [7:0]    prescale_cnt;
    logic [DMSB:0] count;
    logic [DMSB:0] reload;
    logic          tick;
    logic          expiry;

    // Reserved control bits and the snapshot marker carry no state.
    logic unused_bits;
    assign unused_bits = ^{data_in[7:3], double_read};

    // A count load, or a ctrl write that disables, swallows the tick of that cycle.
    always_comb begin
        tick   = (state == ST_RUN) && (prescale_cnt == prescale) && !double_load
                 && !(load_ctrl && !data_in[0]);
        expiry = tick && (count == '0);
    end

    assign expire_pulse        = expiry;
    assign double_data_to_read = count;
    assign ctrl_out            = {prescale, 4'b0000, expired, irq_en, auto_reload, state};

    always_ff @(posedge sysclk) begin
        if (!sysreset) begin
            state        <= ST_IDLE;
            auto_reload  <= 1'b0;
            irq_en       <= 1'b0;
            expired      <= 1'b0;
            prescale     <= '0;
            prescale_cnt <= '0;
            count        <= '0;
            reload       <= '0;
            irq          <= 1'b0;
        end else begin
            if (double_load || load_ctrl || state == ST_IDLE || prescale_cnt == prescale)
                prescale_cnt <= '0;
            else
                prescale_cnt <= prescale_cnt + 8'd1;

            if (double_load) begin
                count  <= double_data_to_write;
                reload <= double_data_to_write;
            end else if (tick) begin
                if (count != '0)
                    count <= count - DW'(1);
                else if (auto_reload)
                    count <= reload;
            end

            if (load_ctrl) begin
                state       <= data_in[0];
                auto_reload <= data_in[1];
                irq_en      <= data_in[2];
                prescale    <= data_in[MSB -: 8];
            end else if (expiry && !auto_reload) begin
                state <= ST_IDLE;
            end

            // Expiry wins over a same-cycle status read so no event is lost.
            if (expiry)
                expired <= 1'b1;
            else if (read_ctrl)
                expired <= 1'b0;

            irq <= expired & irq_en;
        end
    end

endmodule

// File: tb/tb_double_word_countdown_timer.sv
// Bench for double_word_countdown_timer: vector table, hand corner sequences and
// randomized runs checked against an arithmetic model of period/count/flags.
module tb_double_word_countdown_timer;

    localparam int WW = 16;
    localparam int DW = 32;

    logic          sysclk = 1'b0;
    logic          sysreset = 1'b0;
    logic [DW-1:0] double_data_to_write;
    logic          double_load;
    logic [DW-1:0] double_data_to_read;
    logic          double_read;
    logic [WW-1:0] data_in;
    logic          load_ctrl;
    logic          read_ctrl;
    logic [WW-1:0] ctrl_out;
    logic          expire_pulse;
    logic          irq;

    int checks = 0;
    int errors = 0;

    double_word_countdown_timer dut (
        .sysclk               (sysclk),
        .sysreset             (sysreset),
        .double_data_to_write (double_data_to_write),
        .double_load          (double_load),
        .double_data_to_read  (double_data_to_read),
        .double_read          (double_read),
        .data_in              (data_in),
        .load_ctrl            (load_ctrl),
        .read_ctrl            (read_ctrl),
        .ctrl_out             (ctrl_out),
        .expire_pulse         (expire_pulse),
        .irq                  (irq)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic        dld;
        logic [31:0] dw;
        logic        lc;
        logic [15:0] din;
        logic        rc;
        logic [31:0] e_cnt;
        logic [15:0] e_ctrl;
        logic        e_ep;
        logic        e_irq;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic idle_in();
        double_data_to_write = '0;
        double_load          = 1'b0;
        double_read          = 1'b0;
        data_in              = '0;
        load_ctrl            = 1'b0;
        read_ctrl            = 1'b0;
    endtask

    task automatic adv();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        sysreset = 1'b0;
        adv();
        adv();
        sysreset = 1'b1;
    endtask

    // Loads count/reload, then writes control; returns at cycle t=0 of the run.
    task automatic setup_run(input logic [31:0] r, input logic [15:0] cv);
        double_load          = 1'b1;
        double_data_to_write = r;
        adv();
        double_load = 1'b0;
        load_ctrl   = 1'b1;
        data_in     = cv;
        adv();
        load_ctrl = 1'b0;
        data_in   = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, p, per, tmax, n;
        logic ar, ie, en_e, exp_e, irq_e, ep_e;
        logic [31:0] cnt_e;
        logic [15:0] cv;

        vecs[0] = '{1'b1, 32'd3, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'd0, 1'b1, 16'h0001, 1'b0, 32'd3, 16'h0000, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd3, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd2, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0001, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0008, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0008, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b1, 32'd0, 16'h0008, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 32'd0, 1'b0, 16'h0000, 1'b0, 32'd0, 16'h0000, 1'b0, 1'b0};

        idle_in();
        adv();

        // One-shot table, starting from the reset state.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            double_load          = vecs[i].dld;
            double_data_to_write = vecs[i].dw;
            load_ctrl            = vecs[i].lc;
            data_in              = vecs[i].din;
            read_ctrl            = vecs[i].rc;
            @(negedge sysclk);
            chk($sformatf("tbl%0d_count", i), double_data_to_read, vecs[i].e_cnt);
            chk($sformatf("tbl%0d_ctrl", i), 32'(ctrl_out), 32'(vecs[i].e_ctrl));
            chk($sformatf("tbl%0d_pulse", i), 32'(expire_pulse), 32'(vecs[i].e_ep));
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(vecs[i].e_irq));
            adv();
        end
        idle_in();

        // Reset mid-run discards the period.
        do_reset();
        setup_run(32'd100, 16'h0107);
        repeat (5) adv();
        sysreset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            adv();
            @(negedge sysclk);
            chk($sformatf("rst%0d_count", k), double_data_to_read, 32'd0);
            chk($sformatf("rst%0d_ctrl", k), 32'(ctrl_out), 32'd0);
            chk($sformatf("rst%0d_irq", k), 32'(irq), 32'd0);
            chk($sformatf("rst%0d_pulse", k), 32'(expire_pulse), 32'd0);
        end
        adv();
        sysreset = 1'b1;

        // Auto-reload with prescale 1, irq timing, and the read/expiry race.
        do_reset();
        setup_run(32'd2, 16'h0107);
        for (int t = 0; t < 17; t++) begin
            read_ctrl = (t == 11 || t == 12);
            @(negedge sysclk);
            chk($sformatf("ar_t%0d_pulse", t), 32'(expire_pulse), 32'((t % 6) == 5));
            chk($sformatf("ar_t%0d_irq", t), 32'(irq), 32'(t >= 7 && t <= 13));
            chk($sformatf("ar_t%0d_expired", t), 32'(ctrl_out[3]), 32'(t >= 6 && t <= 12));
            if (t == 6) chk("ar_reload_count", double_data_to_read, 32'd2);
            adv();
        end
        idle_in();

        // Load collides with a zero-count tick: load wins, no expiry.
        do_reset();
        setup_run(32'd0, 16'h0003);
        double_load          = 1'b1;
        double_data_to_write = 32'h0001_0000;
        @(negedge sysclk);
        chk("coll_pulse", 32'(expire_pulse), 32'd0);
        adv();
        idle_in();
        @(negedge sysclk);
        chk("coll_count", double_data_to_read, 32'h0001_0000);
        chk("coll_expired", 32'(ctrl_out[3]), 32'd0);
        chk("coll_pulse_next", 32'(expire_pulse), 32'd0);
        adv();

        // Full-width count, two ticks, then a disabling ctrl write suppresses the third.
        do_reset();
        setup_run(32'hFFFF_FFFF, 16'h0001);
        @(negedge sysclk);
        chk("wide_t0", double_data_to_read, 32'hFFFF_FFFF);
        adv();
        @(negedge sysclk);
        chk("wide_t1", double_data_to_read, 32'hFFFF_FFFE);
        adv();
        load_ctrl = 1'b1;
        data_in   = 16'h0000;
        @(negedge sysclk);
        chk("wide_t2", double_data_to_read, 32'hFFFF_FFFD);
        adv();
        idle_in();
        double_read = 1'b1;
        @(negedge sysclk);
        chk("wide_hi", 32'(double_data_to_read[31:16]), 32'h0000_FFFF);
        chk("wide_lo", 32'(double_data_to_read[15:0]), 32'h0000_FFFD);
        chk("wide_ctrl", 32'(ctrl_out), 32'd0);
        adv();
        double_read = 1'b0;
        @(negedge sysclk);
        chk("wide_hold", double_data_to_read, 32'hFFFF_FFFD);
        adv();

        // Randomized runs against the closed-form period model.
        for (int trial = 0; trial < 25; trial++) begin
            r    = int'($urandom_range(0, 12));
            p    = int'($urandom_range(0, 4));
            ar   = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            cv   = {p[7:0], 4'b0000, 1'b0, ie, ar, 1'b1};
            per  = (r + 1) * (p + 1);
            tmax = 2 * per + 4;
            do_reset();
            setup_run(32'(r), cv);
            for (int t = 0; t < tmax; t++) begin
                n = t / (p + 1);
                if (ar) begin
                    cnt_e = 32'(r - (n % (r + 1)));
                    ep_e  = ((t + 1) % per) == 0;
                    en_e  = 1'b1;
                end else begin
                    cnt_e = (t < per) ? 32'(r - n) : 32'd0;
                    ep_e  = (t == per - 1);
                    en_e  = (t < per);
                end
                exp_e = (t >= per);
                irq_e = ie && (t >= per + 1);
                @(negedge sysclk);
                chk($sformatf("rnd%0d_t%0d_count", trial, t), double_data_to_read, cnt_e);
                chk($sformatf("rnd%0d_t%0d_pulse", trial, t), 32'(expire_pulse), 32'(ep_e));
                chk($sformatf("rnd%0d_t%0d_ctrl", trial, t), 32'(ctrl_out),
                    32'({p[7:0], 4'b0000, exp_e, ie, ar, en_e}));
                chk($sformatf("rnd%0d_t%0d_irq", trial, t), 32'(irq), 32'(irq_e));
                adv();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
